// File: rtl/sfm_cast_out_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfm_cast_out_ctrl_pkg
// Brief    : Shared types and helpers for the softmax output cast sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sfm_cast_out_ctrl_pkg;

    localparam int unsigned DATA_W     = 128;
    localparam int unsigned INT_BITS_W = 5;

    typedef struct packed {
        logic                  enable;
        logic                  is_signed;
        logic [INT_BITS_W-1:0] int_bits;
    } cast_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } cast_fsm_state_t;

    // Number of casted lanes that fit in one floating-point lane
    function automatic int unsigned pack_factor(input int unsigned fp_w, input int unsigned int_w);
        return fp_w / int_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfm_cast_out_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sfm_cast_out_ctrl_if
// Brief    : Valid/ready stream bundle with data and byte strobes.
// Revision : 1.0 - initial release
// ============================================================================
interface sfm_cast_out_ctrl_if #(
    parameter int unsigned DATA_WIDTH = sfm_cast_out_ctrl_pkg::DATA_W
);

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);

endinterface
`default_nettype wire

// File: rtl/sfm_cast_out_ctrl_packer.sv
`default_nettype none
// ============================================================================
// Module   : sfm_cast_out_ctrl_packer
// Brief    : Slot buffer, output register and strobe assembly for the packer.
// Revision : 1.0 - initial release
// ============================================================================
module sfm_cast_out_ctrl_packer
    import sfm_cast_out_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned PACK       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pack_en_i,
    input  logic                    in_hs_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    input  logic                    flush_i,
    output logic                    slot_last_o,
    output logic                    out_free_o,
    output logic                    out_valid_o,
    sfm_cast_out_ctrl_if.master     stream_o
);

    localparam int unsigned NW     = DATA_WIDTH / PACK;
    localparam int unsigned NB     = NW / 8;
    localparam int unsigned SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PACK - 1);

    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [PACK-1:0][NW-1:0]     buf_data_q, buf_data_d;
    logic [PACK-1:0][NB-1:0]     buf_strb_q, buf_strb_d;
    logic                        valid_q, valid_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic [DATA_WIDTH/8-1:0]     strb_q, strb_d;

    logic [DATA_WIDTH-1:0]       w_pack_data, w_flush_data;
    logic [DATA_WIDTH/8-1:0]     w_pack_strb, w_flush_strb;
    logic                        w_slot_last;

    assign w_slot_last = (slot_q == SLOT_LAST);

    // Slot 0 lands in the LSBs; the top slot comes straight from the input
    for (genvar g = 0; g < PACK; g++) begin : g_slot
        if (g == PACK - 1) begin : g_in
            assign w_pack_data[g*NW +: NW] = in_data_i[NW-1:0];
            assign w_pack_strb[g*NB +: NB] = in_strb_i[NB-1:0];
        end else begin : g_buf
            assign w_pack_data[g*NW +: NW] = buf_data_q[g];
            assign w_pack_strb[g*NB +: NB] = buf_strb_q[g];
        end
        assign w_flush_data[g*NW +: NW] = (SLOT_W'(g) < slot_q) ? buf_data_q[g] : '0;
        assign w_flush_strb[g*NB +: NB] = (SLOT_W'(g) < slot_q) ? buf_strb_q[g] : '0;
    end

    always_comb begin
        slot_d     = slot_q;
        buf_data_d = buf_data_q;
        buf_strb_d = buf_strb_q;
        valid_d    = valid_q;
        data_d     = data_q;
        strb_d     = strb_q;

        if (stream_o.ready) begin
            valid_d = 1'b0;
        end

        if (in_hs_i && pack_en_i) begin
            if (w_slot_last) begin
                valid_d = 1'b1;
                data_d  = w_pack_data;
                strb_d  = w_pack_strb;
                slot_d  = '0;
            end else begin
                buf_data_d[slot_q] = in_data_i[NW-1:0];
                buf_strb_d[slot_q] = in_strb_i[NB-1:0];
                slot_d             = slot_q + SLOT_W'(1);
            end
        end else if (in_hs_i) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            strb_d  = in_strb_i;
        end else if (flush_i) begin
            valid_d = 1'b1;
            data_d  = w_flush_data;
            strb_d  = w_flush_strb;
            slot_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            slot_q     <= slot_d;
            buf_data_q <= buf_data_d;
            buf_strb_q <= buf_strb_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
        end
    end

    assign stream_o.valid = valid_q;
    assign stream_o.data  = data_q;
    assign stream_o.strb  = strb_q;

    assign slot_last_o = w_slot_last;
    assign out_free_o  = !valid_q || stream_o.ready;
    assign out_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/sfm_cast_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sfm_cast_out_ctrl
// Brief    : Job sequencer for the softmax integer cast stage: latches the cast
//            configuration, counts input beats and packs narrow results.
// Revision : 1.0 - initial release
// ============================================================================
module sfm_cast_out_ctrl
    import sfm_cast_out_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned FP_WIDTH   = 16,
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  cast_ctrl_t           ctrl_i,
    input  logic [CNT_WIDTH-1:0] length_i,
    output cast_ctrl_t           cast_ctrl_o,
    output logic                 busy_o,
    output logic                 done_o,
    sfm_cast_out_ctrl_if.slave   stream_i,
    sfm_cast_out_ctrl_if.master  stream_o
);

    localparam int unsigned NUM_ROWS = DATA_WIDTH / FP_WIDTH;
    localparam int unsigned PACK     = pack_factor(FP_WIDTH, INT_WIDTH);

    cast_fsm_state_t      state_q, state_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    cast_ctrl_t           ctrl_q, ctrl_d;
    logic                 done_q, done_d;

    logic [CNT_WIDTH-1:0] w_beats;
    logic                 w_in_ready;
    logic                 w_in_hs;
    logic                 w_flush;
    logic                 w_slot_last;
    logic                 w_out_free;
    logic                 w_out_valid;

    // Input beats per job: ceil(length / NUM_ROWS)
    assign w_beats = (length_i / CNT_WIDTH'(NUM_ROWS))
                   + CNT_WIDTH'((length_i % CNT_WIDTH'(NUM_ROWS)) != '0);

    // Filling a buffer slot never needs the output register
    assign w_in_ready = (state_q == RUN) && (beat_q != '0)
                     && ((ctrl_q.enable && !w_slot_last) || w_out_free);
    assign w_in_hs    = stream_i.valid && w_in_ready;
    assign stream_i.ready = w_in_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ctrl_d  = ctrl_q;
        done_d  = 1'b0;
        w_flush = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ctrl_d  = ctrl_i;
                    beat_d  = w_beats;
                    state_d = (length_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_in_hs) begin
                    beat_d = beat_q - CNT_WIDTH'(1);
                    if (beat_q == CNT_WIDTH'(1)) begin
                        state_d = (!ctrl_q.enable || w_slot_last) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_out_free) begin
                    w_flush = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!w_out_valid) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    sfm_cast_out_ctrl_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pack_en_i   (ctrl_q.enable),
        .in_hs_i     (w_in_hs),
        .in_data_i   (stream_i.data),
        .in_strb_i   (stream_i.strb),
        .flush_i     (w_flush),
        .slot_last_o (w_slot_last),
        .out_free_o  (w_out_free),
        .out_valid_o (w_out_valid),
        .stream_o    (stream_o)
    );

    assign cast_ctrl_o = ctrl_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sfm_cast_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfm_cast_out_ctrl
// Brief    : Randomized self-checking bench with a queue-based packing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfm_cast_out_ctrl;
    import sfm_cast_out_ctrl_pkg::*;

    localparam int unsigned DW = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    cast_ctrl_t  ctrl = '0;
    logic [31:0] length = '0;
    cast_ctrl_t  cast_ctrl;
    logic        busy;
    logic        done;

    sfm_cast_out_ctrl_if #(.DATA_WIDTH(DW)) s_in ();
    sfm_cast_out_ctrl_if #(.DATA_WIDTH(DW)) s_out ();

    sfm_cast_out_ctrl #(
        .DATA_WIDTH (DW),
        .FP_WIDTH   (16),
        .INT_WIDTH  (8),
        .CNT_WIDTH  (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .ctrl_i      (ctrl),
        .length_i    (length),
        .cast_ctrl_o (cast_ctrl),
        .busy_o      (busy),
        .done_o      (done),
        .stream_i    (s_in),
        .stream_o    (s_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rdy_mode = 1;
    int ndone = 0;
    int jobs_exp = 0;
    cast_ctrl_t cur_cfg = '0;

    logic [127:0] beat_d [32];
    logic [15:0]  beat_s [32];
    logic [127:0] exp_data_q [$];
    logic [15:0]  exp_strb_q [$];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic fill_random(input int nb);
        for (int i = 0; i < nb; i++) begin
            beat_d[i] = {$urandom, $urandom, $urandom, $urandom};
            beat_s[i] = 16'($urandom);
        end
    endtask

    // Reference: low halves of consecutive beats are paired, first in the LSBs
    task automatic build_expect(input int nb, input bit en);
        logic [63:0] lo, hi;
        logic [7:0]  ls, hs;
        if (en) begin
            for (int k = 0; k < nb; k += 2) begin
                lo = beat_d[k][63:0];
                ls = beat_s[k][7:0];
                if (k + 1 < nb) begin
                    hi = beat_d[k+1][63:0];
                    hs = beat_s[k+1][7:0];
                end else begin
                    hi = '0;
                    hs = '0;
                end
                exp_data_q.push_back({hi, lo});
                exp_strb_q.push_back({hs, ls});
            end
        end else begin
            for (int k = 0; k < nb; k++) begin
                exp_data_q.push_back(beat_d[k]);
                exp_strb_q.push_back(beat_s[k]);
            end
        end
    endtask

    initial begin
        s_out.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       s_out.ready = ($urandom_range(0, 1) == 1);
                1:       s_out.ready = 1'b1;
                default: s_out.ready = 1'b0;
            endcase
        end
    end

    // Output monitor: ordering, content, hold stability, configuration
    initial begin
        bit           stall = 1'b0;
        logic [127:0] pd = '0;
        logic [15:0]  ps = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", s_out.valid, 1'b1);
                    chk("hold_data", s_out.data, pd);
                    chk("hold_strb", s_out.strb, ps);
                end
                if (busy) chk("cast_ctrl", cast_ctrl, cur_cfg);
                if (done) ndone++;
                if (s_out.valid && s_out.ready) begin
                    if (exp_data_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %0h expected none", s_out.data);
                    end else begin
                        chk("out_data", s_out.data, exp_data_q.pop_front());
                        chk("out_strb", s_out.strb, exp_strb_q.pop_front());
                    end
                end
                stall = s_out.valid && !s_out.ready;
                pd    = s_out.data;
                ps    = s_out.strb;
            end
        end
    end

    task automatic start_job(input int len, input cast_ctrl_t c);
        @(posedge clk);
        #1;
        start   = 1'b1;
        ctrl    = c;
        length  = len;
        cur_cfg = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ctrl   = cast_ctrl_t'($urandom);
        length = $urandom;
    endtask

    task automatic feed(input int nb, input int mid, input bit bp, input bit lat);
        int acc = 0, hold = 0, cyc = 0;
        bit hs = 1'b0, phs = 1'b0, mid_done = 1'b0;
        logic [127:0] held = '0;
        while (acc < nb) begin
            if (cyc > 3000) begin
                total++;
                bad++;
                $display("FAIL feed_timeout: got %0d beats expected %0d", acc, nb);
                break;
            end
            cyc++;
            s_in.valid = (bp || lat) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_in.data  = beat_d[acc];
            s_in.strb  = beat_s[acc];
            if (acc == mid && !mid_done) begin
                start    = 1'b1;
                ctrl     = cast_ctrl_t'(~cur_cfg);
                length   = $urandom_range(1, 200);
                mid_done = 1'b1;
            end
            @(negedge clk);
            if (lat && phs) begin
                chk("pass_lat_valid", s_out.valid, 1'b1);
                chk("pass_lat_data", s_out.data, beat_d[acc-1]);
            end
            if (bp && acc == 3 && hold < 5) begin
                if (hold == 0) held = s_out.data;
                else chk("bp_data_stable", s_out.data, held);
                chk("bp_in_ready", s_in.ready, 1'b0);
                chk("bp_out_valid", s_out.valid, 1'b1);
                hold++;
                if (hold == 5) rdy_mode = 1;
            end
            hs  = s_in.valid && s_in.ready;
            phs = hs;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hs) acc++;
        end
        s_in.valid = 1'b0;
    endtask

    task automatic wait_done(input bit dtime);
        int cnt = 0;
        bit seen = 1'b0;
        s_in.valid = 1'b1;
        s_in.data  = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            chk("no_extra_accept", s_in.ready, 1'b0);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cnt++;
            end
        end
        s_in.valid = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done pulse");
        end else begin
            chk("busy_at_done", busy, 1'b0);
            chk("out_drained", exp_data_q.size(), 0);
            if (dtime) chk("done_latency", cnt, 2);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("done_pulse_len", done, 1'b0);
        end
    endtask

    task automatic run_job(input int len, input bit en, input int mid, input bit bp,
                           input bit lat, input bit dtime);
        int nb;
        cast_ctrl_t c;
        nb          = (len + 7) / 8;
        c.enable    = en;
        c.is_signed = 1'($urandom);
        c.int_bits  = 5'($urandom_range(1, 8));
        start_job(len, c);
        jobs_exp++;
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
        if (nb == 0) begin
            chk("zero_done_early", done, 1'b0);
            chk("zero_no_out", s_out.valid, 1'b0);
            @(negedge clk);
            chk("zero_done", done, 1'b1);
            chk("zero_busy", busy, 1'b0);
        end else begin
            @(posedge clk);
            #1;
            feed(nb, mid, bp, lat);
            wait_done(dtime);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_in.valid = 1'b0;
        s_in.data  = '0;
        s_in.strb  = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", s_out.valid, 1'b0);
        chk("rst_data", s_out.data, 128'd0);
        chk("rst_strb", s_out.strb, 16'd0);
        chk("rst_cast", cast_ctrl, 7'd0);
        chk("rst_in_ready", s_in.ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four full beats pack into two words
        rdy_mode = 1;
        fill_random(4);
        beat_d[0][63:0] = 64'h0123_4567_89AB_CDEF;
        beat_d[1][63:0] = 64'hFEDC_BA98_7654_3210;
        beat_d[2][63:0] = 64'h1111_2222_3333_4444;
        beat_d[3][63:0] = 64'h5555_6666_7777_8888;
        for (int i = 0; i < 4; i++) beat_s[i] = 16'hFFFF;
        build_expect(4, 1'b1);
        chk("pin_w0", exp_data_q[0], 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
        chk("pin_w1", exp_data_q[1], 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        chk("pin_s0", exp_strb_q[0], 16'hFFFF);
        run_job(32, 1'b1, -1, 1'b0, 1'b0, 1'b1);

        // Odd beat count leaves a half word for the flush
        fill_random(3);
        beat_d[2][63:0] = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 3; i++) beat_s[i] = 16'hFFFF;
        build_expect(3, 1'b1);
        chk("pin_flush_w", exp_data_q[1], 128'h0000_0000_0000_0000_1111_2222_3333_4444);
        chk("pin_flush_s", exp_strb_q[1], 16'h00FF);
        run_job(24, 1'b1, -1, 1'b0, 1'b0, 1'b0);

        // Pass-through
        fill_random(2);
        build_expect(2, 1'b0);
        run_job(16, 1'b0, -1, 1'b0, 1'b1, 1'b0);

        // Backpressure with full output register
        rdy_mode = 2;
        fill_random(8);
        build_expect(8, 1'b1);
        run_job(64, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        rdy_mode = 1;

        // Empty job, then a start pulse in the middle of a job
        run_job(0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;
        fill_random(6);
        build_expect(6, 1'b0);
        run_job(45, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        fill_random(6);
        build_expect(6, 1'b1);
        run_job(41, 1'b1, 3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a job with an output word pending
        rdy_mode = 2;
        fill_random(6);
        build_expect(6, 1'b1);
        start_job(48, cast_ctrl_t'({1'b1, 1'b0, 5'd8}));
        feed(3, -1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", s_out.valid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_data_q.delete();
        exp_strb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        chk("mid_rst_valid", s_out.valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_cast", cast_ctrl, 7'd0);
        fill_random(4);
        build_expect(4, 1'b1);
        run_job(30, 1'b1, -1, 1'b0, 1'b0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            int len;
            bit en;
            len      = $urandom_range(0, 100);
            en       = 1'($urandom);
            rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            fill_random((len + 7) / 8);
            build_expect((len + 7) / 8, en);
            run_job(len, en, ($urandom_range(0, 1) == 1) ? 1 : -1, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("done_count", ndone, jobs_exp);
        chk("leftover_expect", exp_data_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
